rst_seq_ctl: RTL

RST_SEQ_CTL -- requirements
Module: rst_seq_ctl

---
 rtl/rst_seq_ctl.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/rst_seq_ctl.sv
// rst_seq_ctl -- cluster reset sequencer.
//
// Purpose: produces the active-low cluster reset (rst_l), the debug-init
// reset (adbginit_l) and the scan enable (se) for a cluster header buffer.
// The full sequence is HOLD (both resets low for HOLD_CYC cycles), then
// DBG_REL (adbginit_l released, rst_l still low for GAP_CYC cycles), then
// RUN. A warm reset goes RUN -> WARM (rst_l low for HOLD_CYC cycles) -> RUN.
//
// Ports:
//   clk           in   single rising-edge clock
//   reset         in   synchronous active-high reset
//   por_req       in   power-on/full reset request (level)
//   dbg_init_req  in   debug-init request (full sequence)
//   wmr_req       in   warm reset request (rst_l only)
//   scan_en_req   in   requested scan enable
//   rst_l         out  active-low cluster reset
//   adbginit_l    out  active-low debug-init reset
//   se            out  scan enable
//   seq_busy      out  high whenever state is not RUN
//   seq_done      out  one-cycle pulse after each entry into RUN
//   seq_state     out  HOLD=0, DBG_REL=1, WARM=2, RUN=3
//
// Configuration macro: RST_SEQ_SCAN_EN -- when defined, se is a flop that
// follows scan_en_req while in RUN; otherwise se is constant 0.
module rst_seq_ctl #(
  parameter int unsigned HOLD_CYC = 16,
  parameter int unsigned GAP_CYC  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       por_req,
  input  logic       dbg_init_req,
  input  logic       wmr_req,
  input  logic       scan_en_req,
  output logic       rst_l,
  output logic       adbginit_l,
  output logic       se,
  output logic       seq_busy,
  output logic       seq_done,
  output logic [2:0] seq_state
);

  typedef enum logic [2:0] {
    ST_HOLD    = 3'd0,
    ST_DBG_REL = 3'd1,
    ST_WARM    = 3'd2,
    ST_RUN     = 3'd3
  } state_e;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYC - 1);
  localparam logic [7:0] GAP_LAST  = 8'(GAP_CYC - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  // entry_q marks that the previous edge moved us into RUN; seq_done is
  // registered from it so the pulse lands one cycle after RUN entry.
  logic       entry_q, entry_d;
  logic       done_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_HOLD;
      cnt_q   <= 8'd0;
      entry_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      entry_q <= entry_d;
      done_q  <= entry_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 8'd1;
    case (state_q)
      ST_HOLD: begin
        // dbg_init_req is already being serviced here, only por restarts
        if (por_req) begin
          cnt_d = 8'd0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = ST_DBG_REL;
          cnt_d   = 8'd0;
        end
      end
      ST_DBG_REL: begin
        if (por_req || dbg_init_req) begin
          state_d = ST_HOLD;
          cnt_d   = 8'd0;
        end else if (cnt_q == GAP_LAST) begin
          state_d = ST_RUN;
          cnt_d   = 8'd0;
        end
      end
      ST_WARM: begin
        if (por_req || dbg_init_req) begin
          state_d = ST_HOLD;
          cnt_d   = 8'd0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = ST_RUN;
          cnt_d   = 8'd0;
        end
      end
      ST_RUN: begin
        cnt_d = 8'd0;
        if (por_req || dbg_init_req) begin
          state_d = ST_HOLD;
        end else if (wmr_req) begin
          state_d = ST_WARM;
        end
      end
      default: begin
        state_d = ST_HOLD;
        cnt_d   = 8'd0;
      end
    endcase
    entry_d = (state_d == ST_RUN) && (state_q != ST_RUN);
  end

  assign rst_l      = (state_q == ST_RUN);
  assign adbginit_l = (state_q != ST_HOLD);
  assign seq_busy   = (state_q != ST_RUN);
  assign seq_state  = state_q;
  assign seq_done   = done_q;

`ifdef RST_SEQ_SCAN_EN
  logic se_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      se_q <= 1'b0;
    end else begin
      se_q <= (state_q == ST_RUN) ? scan_en_req : 1'b0;
    end
  end

  assign se = se_q;
`else
  logic unused_scan_en;
  assign unused_scan_en = scan_en_req;
  assign se = 1'b0;
`endif

endmodule
